// File: rtl/bram_ctrl_pkg.sv
// Shared types and constants for the binary frame BRAM controller.
package bram_ctrl_pkg;

    localparam int FRAME_PIXELS_DEFAULT = 307200;
    localparam int NUM_REQ              = 2;

    typedef logic [0:0] req_idx_t;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input req_idx_t idx);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a per-requester block mask.
// Blocked requesters are invisible to arbitration and leave the pointer untouched.
module rr_arbiter2
    import bram_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] block_i,
    output logic [NUM_REQ-1:0] grant_o,
    output req_idx_t           grant_idx_o
);

    logic [NUM_REQ-1:0] elig_s;
    req_idx_t           last_q;
    req_idx_t           last_d;

    // Pick the eligible requester, preferring the one not served last on a tie.
    always_comb begin
        elig_s      = req_i & ~block_i;
        grant_o     = '0;
        grant_idx_o = 1'b0;
        last_d      = last_q;
        case (elig_s)
            2'b11: begin
                grant_idx_o = ~last_q;
                grant_o     = idx_to_onehot(~last_q);
                last_d      = ~last_q;
            end
            2'b01: begin
                grant_idx_o = 1'b0;
                grant_o     = 2'b01;
                last_d      = 1'b0;
            end
            2'b10: begin
                grant_idx_o = 1'b1;
                grant_o     = 2'b10;
                last_d      = 1'b1;
            end
            default: begin
                grant_idx_o = 1'b0;
                grant_o     = 2'b00;
                last_d      = last_q;
            end
        endcase
    end

    // Pointer resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/simple_dual_port_bram.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle latency).
module simple_dual_port_bram #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage array and registered read; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bram_read_arbiter.sv
// Frame BRAM controller: sequential pixel write addressing plus a shared,
// hazard-aware round-robin read port for the matcher and display requesters.
module bram_read_arbiter
    import bram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH   = 19,
    parameter int DATA_WIDTH   = 1,
    parameter int FRAME_PIXELS = FRAME_PIXELS_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          pix_valid,
    input  logic                          pix_sof,
    input  logic [DATA_WIDTH-1:0]         pix_data,
    output logic                          frame_done,
    output logic                          frame_ready,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_grant,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          bram_we,
    output logic [ADDR_WIDTH-1:0]         bram_waddr,
    output logic [DATA_WIDTH-1:0]         bram_wdata,
    output logic [ADDR_WIDTH-1:0]         bram_raddr,
    input  logic [DATA_WIDTH-1:0]         bram_rdata
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_PIXELS - 1);

    logic [ADDR_WIDTH-1:0] wptr_q;
    logic [ADDR_WIDTH-1:0] wptr_d;
    logic [ADDR_WIDTH-1:0] waddr_s;
    logic                  last_pix_s;
    logic                  frame_done_q;
    logic                  frame_done_d;
    logic                  frame_ready_q;
    logic                  frame_ready_d;
    logic [ADDR_WIDTH-1:0] raddr_q;
    logic [ADDR_WIDTH-1:0] raddr_d;
    logic [NUM_REQ-1:0]    rsp_valid_q;
    logic [NUM_REQ-1:0]    hazard_s;
    logic [NUM_REQ-1:0]    grant_s;
    req_idx_t              grant_idx_s;
    logic [ADDR_WIDTH-1:0] req_addr_s [NUM_REQ];

    // Write address generation and frame completion tracking; sof overrides the last pixel.
    always_comb begin
        waddr_s    = pix_sof ? '0 : wptr_q;
        last_pix_s = pix_valid && !pix_sof && (wptr_q == LAST_ADDR);
        if (pix_valid) begin
            if (waddr_s == LAST_ADDR) begin
                wptr_d = '0;
            end else begin
                wptr_d = waddr_s + 1'b1;
            end
        end else begin
            wptr_d = wptr_q;
        end
        frame_done_d = last_pix_s;
        if (pix_valid && pix_sof) begin
            frame_ready_d = 1'b0;
        end else if (last_pix_s) begin
            frame_ready_d = 1'b1;
        end else begin
            frame_ready_d = frame_ready_q;
        end
    end

    // A read of the address being written this cycle would return stale data, so hold it off.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr_s[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            hazard_s[i]   = pix_valid && (req_addr_s[i] == waddr_s);
        end
    end

    rr_arbiter2 u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_valid),
        .block_i     (hazard_s),
        .grant_o     (grant_s),
        .grant_idx_o (grant_idx_s)
    );

    // Read address follows the winner and parks on the last granted address otherwise.
    always_comb begin
        if (|grant_s) begin
            raddr_d = req_addr_s[grant_idx_s];
        end else begin
            raddr_d = raddr_q;
        end
    end

    // State registers: write pointer, frame flags, parked read address, response strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q        <= '0;
            frame_done_q  <= 1'b0;
            frame_ready_q <= 1'b0;
            raddr_q       <= '0;
            rsp_valid_q   <= '0;
        end else begin
            wptr_q        <= wptr_d;
            frame_done_q  <= frame_done_d;
            frame_ready_q <= frame_ready_d;
            raddr_q       <= raddr_d;
            rsp_valid_q   <= grant_s;
        end
    end

    assign bram_we     = pix_valid;
    assign bram_wdata  = pix_data;
    assign bram_waddr  = waddr_s;
    assign bram_raddr  = raddr_d;
    assign req_grant   = grant_s;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = bram_rdata;
    assign frame_done  = frame_done_q;
    assign frame_ready = frame_ready_q;

endmodule
